stopwatch_lap: RTL and testbench

Parametrised stopwatch for the board-level display path: debounces start/stop/clear/lap buttons, runs an N-digit BCD counter advancing once every TICK_DIV clocks, and drives a time-multiplexed, active-low seven-segment display. It generalises the fixed 4-digit start/stop/clear stopwatch to configurable digit count, debounce and refresh timing. It adds a lap-freeze display mode and an overflow indication, and sits directly under the board wrapper.

---
 rtl/stopwatch_lap_pkg.sv | 56 +++++
 rtl/stopwatch_lap_if.sv | 29 ++
 rtl/stopwatch_lap_btn_debounce.sv | 48 ++++
 rtl/stopwatch_lap.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_lap.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_lap_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch_lap block.
//   sw_state_t    - controller states
//   sw_cmd_t      - single command chosen from same-cycle button pulses
//   BTN_*         - bit positions of the button pulses in a 4-bit vector
//   resolve_cmd() - picks one command: clear > stop > start > lap
//   seg7_decode() - BCD to active-low {g,f,e,d,c,b,a}; non-BCD is blank
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sw_state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_CLEAR = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_START = 3'd3,
        CMD_LAP   = 3'd4
    } sw_cmd_t;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int BTN_LAP   = 3;

    function automatic sw_cmd_t resolve_cmd(input logic [3:0] pulses);
        sw_cmd_t cmd;
        cmd = CMD_NONE;
        if (pulses[BTN_CLEAR])      cmd = CMD_CLEAR;
        else if (pulses[BTN_STOP])  cmd = CMD_STOP;
        else if (pulses[BTN_START]) cmd = CMD_START;
        else if (pulses[BTN_LAP])   cmd = CMD_LAP;
        return cmd;
    endfunction

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b100_0000;
            4'd1:    seg = 7'b111_1001;
            4'd2:    seg = 7'b010_0100;
            4'd3:    seg = 7'b011_0000;
            4'd4:    seg = 7'b001_1001;
            4'd5:    seg = 7'b001_0010;
            4'd6:    seg = 7'b000_0010;
            4'd7:    seg = 7'b111_1000;
            4'd8:    seg = 7'b000_0000;
            4'd9:    seg = 7'b001_0000;
            default: seg = 7'b111_1111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// stopwatch_lap_if: board-facing signals of the stopwatch.
//   start/stop/clear/lap - raw push-buttons, active-high
//   an                   - digit enables, active-low one-hot
//   sseg                 - {dp,g,f,e,d,c,b,a}, active-low
//   running/lap_active/overflow - status
// master = board/testbench side, slave = stopwatch side.
interface stopwatch_lap_if #(
    parameter int N_DIGITS = 4
);
    logic                start;
    logic                stop;
    logic                clear;
    logic                lap;
    logic [N_DIGITS-1:0] an;
    logic [7:0]          sseg;
    logic                running;
    logic                lap_active;
    logic                overflow;

    modport master (
        output start, stop, clear, lap,
        input  an, sseg, running, lap_active, overflow
    );

    modport slave (
        input  start, stop, clear, lap,
        output an, sseg, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_lap_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debouncer for one push-button.
//   clk, rst_n - clock, synchronous active-low reset
//   btn_raw    - asynchronous button input
//   btn_pulse  - one-cycle pulse on an accepted rising edge
// A new level is accepted after DEBOUNCE_CYC consecutive samples that differ
// from the current stable level; the pulse lands 2 + DEBOUNCE_CYC clocks
// after the raw input rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= RELOAD;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_pulse <= 1'b0;
            if (r_sync[1] != r_stable) begin
                if (r_cnt == '0) begin
                    r_stable <= r_sync[1];
                    r_pulse  <= r_sync[1];
                    r_cnt    <= RELOAD;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end else begin
                r_cnt <= RELOAD;
            end
        end
    end

    assign btn_pulse = r_pulse;
endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: N-digit BCD stopwatch with lap freeze and multiplexed
// active-low seven-segment output.
//   clk, rst_n - clock, synchronous active-low reset
//   sw         - stopwatch_lap_if.slave: buttons in; an/sseg/status out
//
//   state | meaning
//   IDLE  | count zero, prescaler stopped
//   RUN   | prescaler running, count advances on each tick
//   HOLD  | count and prescaler frozen, start resumes
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 1_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REFRESH_CYC  = 100_000,
    parameter int DP_POS       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_lap_if.slave  sw
);
    localparam int CNT_W = 4 * N_DIGITS;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW    = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int IW    = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [3:0]          w_pulse;
    sw_cmd_t             w_cmd;
    sw_state_t           r_state;
    sw_state_t           w_state_nxt;
    logic                w_tick;
    logic                w_wrap;
    logic [CNT_W-1:0]    w_count_inc;
    logic [CNT_W-1:0]    w_disp;
    logic [3:0]          w_digit;
    logic                w_dp_on;

    logic [PW-1:0]       r_presc;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_lap;
    logic                r_lap_active;
    logic                r_overflow;
    logic                r_running;
    logic [RW-1:0]       r_ref;
    logic [IW-1:0]       r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_sseg;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .clk(clk), .rst_n(rst_n), .btn_raw(sw.start), .btn_pulse(w_pulse[BTN_START]));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (
        .clk(clk), .rst_n(rst_n), .btn_raw(sw.stop),  .btn_pulse(w_pulse[BTN_STOP]));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
        .clk(clk), .rst_n(rst_n), .btn_raw(sw.clear), .btn_pulse(w_pulse[BTN_CLEAR]));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
        .clk(clk), .rst_n(rst_n), .btn_raw(sw.lap),   .btn_pulse(w_pulse[BTN_LAP]));

    // Lower-priority pulses in the same cycle are dropped, even when the
    // winning command has no effect in the current state.
    assign w_cmd = resolve_cmd(w_pulse);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (w_cmd)
            CMD_CLEAR: w_state_nxt = IDLE;
            CMD_STOP:  if (r_state == RUN) w_state_nxt = HOLD;
            CMD_START: if (r_state != RUN) w_state_nxt = RUN;
            default:   w_state_nxt = r_state;
        endcase
    end

    assign w_tick = (r_state == RUN) && (r_presc == PRE_LAST);

    // Ripple increment across all digits; w_wrap stays set only if every
    // digit was 9.
    always_comb begin
        w_count_inc = r_count;
        w_wrap      = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_wrap) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_wrap                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_count      <= '0;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_running <= (w_state_nxt == RUN);
            if (w_cmd == CMD_CLEAR) begin
                r_presc      <= '0;
                r_count      <= '0;
                r_lap        <= '0;
                r_lap_active <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (r_state == RUN) begin
                    if (w_tick) begin
                        r_presc <= '0;
                        r_count <= w_count_inc;
                        if (w_wrap) r_overflow <= 1'b1;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                // Capture takes the count as it stood before this cycle's tick.
                if ((w_cmd == CMD_LAP) && (r_state == RUN)) begin
                    r_lap_active <= ~r_lap_active;
                    if (!r_lap_active) r_lap <= r_count;
                end
            end
        end
    end

    assign w_disp  = r_lap_active ? r_lap : r_count;
    assign w_digit = w_disp[4*r_idx +: 4];
    assign w_dp_on = (int'(r_idx) == DP_POS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref  <= REF_RELOAD;
            r_idx  <= '0;
            r_an   <= ~AN_ONE;
            r_sseg <= {(DP_POS == 0) ? 1'b0 : 1'b1, 7'b100_0000};
        end else begin
            if (r_ref == '0) begin
                r_ref <= REF_RELOAD;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_ref <= r_ref - RW'(1);
            end
            r_an   <= ~(AN_ONE << r_idx);
            r_sseg <= {~w_dp_on, seg7_decode(w_digit)};
        end
    end

    assign sw.an         = r_an;
    assign sw.sseg       = r_sseg;
    assign sw.running    = r_running;
    assign sw.lap_active = r_lap_active;
    assign sw.overflow   = r_overflow;
endmodule

// File: tb/tb_stopwatch_lap.sv
module tb_stopwatch_lap;
    localparam int N_DIGITS     = 4;
    localparam int TICK_DIV     = 3;
    localparam int DEBOUNCE_CYC = 4;
    localparam int REFRESH_CYC  = 2;
    localparam int DP_POS       = 2;
    localparam int MODULUS      = 10000;

    localparam logic [3:0] B_START = 4'b0001;
    localparam logic [3:0] B_STOP  = 4'b0010;
    localparam logic [3:0] B_CLEAR = 4'b0100;
    localparam logic [3:0] B_LAP   = 4'b1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_lap_if #(.N_DIGITS(N_DIGITS)) sw_if ();

    stopwatch_lap #(
        .N_DIGITS(N_DIGITS), .TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REFRESH_CYC(REFRESH_CYC), .DP_POS(DP_POS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural reference: time spent running, ticks since last clear.
    int       m_run_clk = 0;
    int       m_ticks   = 0;
    bit       m_run     = 0;
    bit       m_lap_on  = 0;
    int       m_lap_val = 0;
    logic [3:0] m_pend  = 4'b0000;

    always @(posedge clk) begin
        int cnt_before;
        if (!rst_n) begin
            m_run_clk = 0; m_ticks = 0; m_run = 0; m_lap_on = 0; m_lap_val = 0;
        end else begin
            cnt_before = m_ticks % MODULUS;
            if (m_pend[2]) begin
                m_run_clk = 0; m_ticks = 0; m_run = 0; m_lap_on = 0;
            end else begin
                if (m_run) begin
                    m_run_clk++;
                    if (m_run_clk % TICK_DIV == 0) m_ticks++;
                end
                if (m_pend[1])      m_run = 0;
                else if (m_pend[0]) m_run = 1;
                else if (m_pend[3] && m_run) begin
                    if (!m_lap_on) m_lap_val = cnt_before;
                    m_lap_on = !m_lap_on;
                end
            end
        end
    end

    typedef struct {
        int tag;
        int disp;
        bit chk_disp;
        bit running;
        bit lap_active;
        bit overflow;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_busy = 0;

    function automatic int seg_to_digit(input logic [6:0] s);
        case (s)
            7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
            7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
            7'h00: return 8;  7'h10: return 9;
            default: return -1;
        endcase
    endfunction

    // Monitor: pops an expectation and reconstructs the shown value from one
    // full multiplex scan.
    initial begin
        exp_t e;
        int   dig [N_DIGITS];
        bit   seen [N_DIGITS];
        bit   an_ok, dp_ok, all_seen;
        int   pos, val, scale;
        logic [N_DIGITS-1:0] oh;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_busy = 1;
                e = sb_q.pop_front();
                chk($sformatf("item%0d running", e.tag), int'(sw_if.running), int'(e.running));
                chk($sformatf("item%0d lap_active", e.tag), int'(sw_if.lap_active), int'(e.lap_active));
                chk($sformatf("item%0d overflow", e.tag), int'(sw_if.overflow), int'(e.overflow));
                for (int k = 0; k < N_DIGITS; k++) begin seen[k] = 0; dig[k] = -1; end
                an_ok = 1; dp_ok = 1;
                for (int s = 0; s < N_DIGITS * REFRESH_CYC; s++) begin
                    if (s > 0) @(negedge clk);
                    pos = -1;
                    for (int k = 0; k < N_DIGITS; k++) begin
                        oh = '0; oh[k] = 1'b1;
                        if (sw_if.an == ~oh) pos = k;
                    end
                    if (pos < 0) an_ok = 0;
                    else begin
                        seen[pos] = 1;
                        dig[pos]  = seg_to_digit(sw_if.sseg[6:0]);
                        if (sw_if.sseg[7] != (pos != DP_POS)) dp_ok = 0;
                    end
                end
                all_seen = 1;
                for (int k = 0; k < N_DIGITS; k++) if (!seen[k]) all_seen = 0;
                chk($sformatf("item%0d an scan", e.tag), int'(an_ok && all_seen), 1);
                chk($sformatf("item%0d dp", e.tag), int'(dp_ok), 1);
                if (e.chk_disp) begin
                    val = 0; scale = 1;
                    for (int k = 0; k < N_DIGITS; k++) begin
                        if (dig[k] < 0) val = -1000000;
                        val += dig[k] * scale;
                        scale *= 10;
                    end
                    chk($sformatf("item%0d display", e.tag), val, e.disp);
                end
                mon_busy = 0;
            end
        end
    end

    task automatic drain();
        int g = 0;
        while ((sb_q.size() != 0 || mon_busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_checks++; n_errors++;
            $display("FAIL drain timeout: got pending=%0d, expected 0", sb_q.size());
        end
    endtask

    task automatic expect_now(input int tag);
        exp_t e;
        e.tag        = tag;
        e.disp       = m_lap_on ? m_lap_val : (m_ticks % MODULUS);
        e.chk_disp   = !(m_run && !m_lap_on);
        e.running    = m_run;
        e.lap_active = m_lap_on;
        e.overflow   = (m_ticks >= MODULUS);
        sb_q.push_back(e);
        drain();
    endtask

    task automatic drive_btn(input logic [3:0] m);
        sw_if.start = m[0];
        sw_if.stop  = m[1];
        sw_if.clear = m[2];
        sw_if.lap   = m[3];
    endtask

    // Raw press held for 'hold' clocks; the pulse reaches the controller on
    // the (DEBOUNCE_CYC+3)-th rising edge after the press.
    task automatic press(input logic [3:0] mask, input int hold, input bit chk_lat);
        @(negedge clk);
        drive_btn(mask);
        repeat (DEBOUNCE_CYC + 2) @(posedge clk);
        @(negedge clk);
        m_pend = mask;
        if (chk_lat) chk("latency before", int'(sw_if.running), 0);
        @(negedge clk);
        m_pend = 4'b0000;
        if (chk_lat) chk("latency after", int'(sw_if.running), 1);
        repeat (hold - 8) @(negedge clk);
        drive_btn(4'b0000);
        repeat (DEBOUNCE_CYC + 4) @(negedge clk);
    endtask

    task automatic wait_ticks(input int target);
        int g = 0;
        while (m_ticks < target && g < 40000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40000) begin
            n_checks++; n_errors++;
            $display("FAIL tick wait: got %0d, expected %0d", m_ticks, target);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, " an"}, int'(sw_if.an), int'(4'b1110));
        chk({pfx, " sseg"}, int'(sw_if.sseg), int'(8'b1100_0000));
        chk({pfx, " running"}, int'(sw_if.running), 0);
        chk({pfx, " lap_active"}, int'(sw_if.lap_active), 0);
        chk({pfx, " overflow"}, int'(sw_if.overflow), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mask;
        drive_btn(4'b0000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Start with latency check, run, stop, hold frozen, resume.
        press(B_START, 20, 1);
        repeat (60) @(negedge clk);
        press(B_STOP, 10, 0);
        expect_now(1);
        repeat (50) @(negedge clk);
        expect_now(2);
        press(B_START, 10, 0);
        repeat (20) @(negedge clk);
        press(B_STOP, 10, 0);
        expect_now(3);

        // Lap freeze, release, stop while lapped.
        press(B_START, 10, 0);
        repeat (30) @(negedge clk);
        press(B_LAP, 10, 0);
        expect_now(4);
        repeat (40) @(negedge clk);
        expect_now(5);
        press(B_LAP, 20, 0);
        expect_now(6);
        press(B_LAP, 10, 0);
        press(B_STOP, 10, 0);
        expect_now(7);
        press(B_LAP, 10, 0);
        expect_now(8);
        press(B_START, 10, 0);
        press(B_LAP, 10, 0);
        press(B_STOP, 10, 0);
        expect_now(9);

        // Same-cycle start/stop/clear in RUN, then ignored commands in IDLE.
        press(B_START, 10, 0);
        repeat (15) @(negedge clk);
        press(B_START | B_STOP | B_CLEAR, 12, 0);
        expect_now(10);
        press(B_STOP, 10, 0);
        press(B_LAP, 10, 0);
        expect_now(11);
        press(B_START | B_STOP, 10, 0);
        expect_now(12);

        // Random button traffic.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 8) mask = 4'b0001 << $urandom_range(0, 3);
            else                          mask = 4'($urandom_range(1, 15));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            press(mask, $urandom_range(8, 24), 0);
            expect_now(100 + i);
        end

        // Wrap at all-9s and sticky overflow, then clear.
        press(B_CLEAR, 10, 0);
        press(B_START, 10, 0);
        wait_ticks(MODULUS - 5);
        press(B_STOP, 10, 0);
        expect_now(200);
        press(B_START, 10, 0);
        wait_ticks(MODULUS + 2);
        press(B_STOP, 10, 0);
        expect_now(201);
        press(B_START, 10, 0);
        repeat (20) @(negedge clk);
        press(B_STOP, 10, 0);
        expect_now(202);
        press(B_CLEAR, 10, 0);
        expect_now(203);

        // Reset in the middle of a lapped run.
        press(B_START, 10, 0);
        repeat (25) @(negedge clk);
        press(B_LAP, 10, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_now(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
